maxpool_ctrl: RTL and testbench
===============================

# maxpool_ctrl

Sequencer for the max-pooling stage of the MVU output path. It accepts a stream of signed accumulator results and groups them into pooling windows of `win_size` elements, for `num_win` windows per job. It drives the `max_clr`/`max_pool`/`I` controls of an internal `maxpool` instance and flags each finished window maximum with a one-cycle `out_valid`. Windows run back-to-back without bubbles.

## Interface
Parameters:
- `N`, 32: data width, signed two's complement.
- `CNTW`, 8: width of the window-size and window-count config fields.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: one-cycle job start. Sampled only in IDLE.
- `win_size`, in, CNTW: elements per window. Latched in LOAD.
- `num_win`, in, CNTW: windows per job. Latched in LOAD.
- `in_valid`, in, 1: `in_data` is valid this cycle.
- `in_data`, in, N: signed input element.
- `in_ready`, out, 1: high in RUN. An element is accepted when `in_valid & in_ready`.
- `out_data`, out, N: signed window maximum. This is the `O` output of the maxpool instance.
- `out_valid`, out, 1: `out_data` holds a completed window maximum.
- `busy`, out, 1: high in LOAD and RUN.
- `done`, out, 1: one-cycle pulse when the job completes.

## Operation
States: IDLE, LOAD, RUN, FIN.
- **IDLE**
  - Drives `max_pool=1`, `max_clr=0`, `I=MIN` (−2^(N−1)), so `O` holds its value.
  - `start=1` moves to LOAD.
- **LOAD** (one cycle)
  - Latches `win_size` and `num_win`.
  - Clears `elem_cnt` and `win_cnt`.
  - Drives `max_clr=1`, `max_pool=1`, `I=MIN`, so `O` becomes 0.
  - If either latched value is 0, goes to FIN. Otherwise goes to RUN.
- **RUN**, accepted element:
  - Drives `I=in_data`.
  - `max_pool=0` when `elem_cnt==0` (plain set, first element of the window). Otherwise `max_pool=1` (O = max(O, I)).
  - `elem_cnt` increments. When it reaches `win_size−1` it wraps to 0, `win_cnt` increments, and `out_valid` is registered for the next cycle.
- **RUN**, no element:
  - Drives `max_pool=1`, `I=MIN`. `O` and the counters hold. Stalls can fall anywhere inside a window.
- **RUN to FIN:** when the last element of the last window is accepted.
- **FIN** (one cycle)
  - `done=1`, `busy=0`, `in_ready=0`.
  - Drives hold controls (`max_pool=1`, `I=MIN`).
  - Goes to IDLE.
- `win_size=1`: every element is a plain set, and `out_valid` follows each accepted element by one cycle.
- `out_data` is not reset: the maxpool instance has no reset. Its power-up value is 0 (register init), and it is guaranteed 0 after LOAD. After FIN it keeps the last maximum until the next LOAD.
- `start` while not in IDLE is ignored.
- Comparison is signed. Window maxima of all-negative data must be correct. `MIN` never wins against real data except when the data equals `MIN`, and that gives the same result.

## Timing
- `start` high at cycle t: LOAD at t+1 and RUN at t+2. `busy` is high from t+1.
- Last element of a window accepted at cycle k:
  - `out_valid=1` and `out_data` equal to the window max at k+1, for exactly one cycle.
  - A first element of the next window accepted at k+1 overwrites `O` at the k+2 edge. There is no conflict.
- Last element of the job accepted at k: `out_valid` and `done` are both high at k+1 (FIN), and `in_ready=0` at k+1.
- Zero-length job: `start` at t gives `done` at t+2, and `out_valid` is never asserted.
- Latency from element to result: 1 cycle after the window's last element.
- `rst` asserted, including mid-job:
  - Immediately: state IDLE, counters 0, `out_valid=0`, `done=0`, `busy=0`, `in_ready=0`.
  - The window in progress is discarded.
  - `O` is not cleared until the next LOAD.

## Structure
- Shared package `maxpool_ctrl_pkg`:
  - state enum (IDLE, LOAD, RUN, FIN);
  - function returning `MIN` for width N.
- One sub-module, `maxpool` (existing), instantiated as the datapath. The input mux, counters and FSM live in `maxpool_ctrl`.

## Test plan
- **Basic:** `win_size=4`, `num_win=2`; data 3, −7, 9, 1 | −2, −5, −1, −8, all back-to-back. Required: `out_valid` twice, `out_data` 9 then −1; `done` in the cycle of the second `out_valid`.
- **Stalls:** same data as Basic, with `in_valid` low for 3 cycles after the 2nd element of each window. Required: identical results; `O` unchanged during stalls.
- **Pass-through:** `win_size=1`, `num_win=3`; data −4, 5, 0. Required: `out_valid` three consecutive cycles with −4, 5, 0.
- **Zero config:** `win_size=0`, `num_win=5`. Required: `done` 2 cycles after `start`; no `out_valid`; `in_ready` never high; `out_data=0`.
- **Reset mid-job:** assert `rst` after 2 of 4 elements. Required: outputs idle immediately. A new job with `win_size=2`, data −3, −6 returns −3.
- **Edge values and ignored start:** data `MIN`, `MIN` (`win_size=2`) returns `MIN`; data 2^(N−1)−1, 0 returns 2^(N−1)−1. `start` pulsed during RUN has no effect.

Source files
------------

// File: rtl/maxpool_ctrl_pkg.sv
// maxpool_ctrl_pkg: shared state encoding and signed-minimum helper for the max-pool sequencer
package maxpool_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;
  function automatic logic [63:0] min_val(input int n);
    return -(64'sd1 <<< (n - 1));
  endfunction
endpackage

// File: rtl/maxpool.sv
// maxpool: running signed maximum register with clear, plain-set and max-update modes
module maxpool #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         max_clr,
  input  logic         max_pool,
  input  logic [N-1:0] I,
  output logic [N-1:0] O
);
  logic signed [N-1:0] o_q = '0;
  // clear to 0, plain set when not pooling, otherwise keep the larger signed value
  always_ff @(posedge clk)
    o_q <= max_clr ? '0 : (!max_pool || $signed(I) > o_q) ? I : o_q;
  assign O = o_q;
endmodule

// File: rtl/maxpool_ctrl.sv
// maxpool_ctrl: sequences element windows through a maxpool datapath and flags each window maximum
module maxpool_ctrl
  import maxpool_ctrl_pkg::*;
#(
  parameter int N    = 32,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CNTW-1:0] win_size,
  input  logic [CNTW-1:0] num_win,
  input  logic            in_valid,
  input  logic [N-1:0]    in_data,
  output logic            in_ready,
  output logic [N-1:0]    out_data,
  output logic            out_valid,
  output logic            busy,
  output logic            done
);
  localparam logic [N-1:0] MIN = N'(min_val(N));
  state_t          state;
  logic [CNTW-1:0] ws_q, nw_q, elem_cnt, win_cnt;
  logic            accept, last_elem, last_win, max_clr, max_pool;
  logic [N-1:0]    mp_in;
  // datapath controls: MIN on the input with pooling enabled is a hold
  always_comb begin
    accept    = in_ready & in_valid;
    last_elem = elem_cnt == ws_q - CNTW'(1);
    last_win  = win_cnt == nw_q - CNTW'(1);
    max_clr   = state == LOAD;
    max_pool  = !(accept && elem_cnt == '0);
    mp_in     = accept ? in_data : MIN;
  end
  // job sequencer with registered handshake and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ws_q      <= '0;
      nw_q      <= '0;
      elem_cnt  <= '0;
      win_cnt   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          busy  <= 1'b1;
        end
        LOAD: begin
          ws_q     <= win_size;
          nw_q     <= num_win;
          elem_cnt <= '0;
          win_cnt  <= '0;
          if (win_size == '0 || num_win == '0) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= RUN;
            in_ready <= 1'b1;
          end
        end
        RUN: if (accept) begin
          elem_cnt <= last_elem ? '0 : elem_cnt + CNTW'(1);
          if (last_elem) begin
            win_cnt   <= win_cnt + CNTW'(1);
            out_valid <= 1'b1;
            if (last_win) begin
              state    <= FIN;
              busy     <= 1'b0;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  maxpool #(.N(N)) u_maxpool (
    .clk      (clk),
    .max_clr  (max_clr),
    .max_pool (max_pool),
    .I        (mp_in),
    .O        (out_data)
  );
endmodule

// File: tb/tb_maxpool_ctrl.sv
// tb_maxpool_ctrl: directed jobs checked every cycle against a queue-based window-max model
module tb_maxpool_ctrl;
  localparam logic signed [31:0] MINV = 32'sh8000_0000;
  localparam logic signed [31:0] MAXV = 32'sh7fff_ffff;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [7:0]  win_size = '0, num_win = '0;
  logic [31:0] in_data = '0;
  logic        in_ready, out_valid, busy, done;
  logic [31:0] out_data;
  int total = 0, passed = 0;
  bit armed = 1'b0;
  int ph = 0, left = 0, m_ws = 0;
  logic signed [31:0] wq[$], got[$], want[$];
  logic signed [31:0] e_o = '0;
  logic e_ov = 1'b0, e_done = 1'b0, e_busy, e_rdy;

  maxpool_ctrl #(.N(32), .CNTW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .win_size(win_size), .num_win(num_win),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // behavioural model: phase 0 idle, 1 load, 2 run, 3 fin; windows gathered in a queue
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = 0; e_ov = 0; e_done = 0; wq.delete();
    end else begin
      e_ov = 0; e_done = 0;
      case (ph)
        0: if (start) ph = 1;
        1: begin
          m_ws = int'(win_size);
          left = m_ws * int'(num_win);
          wq.delete();
          e_o = 0;
          if (left == 0) begin ph = 3; e_done = 1; end else ph = 2;
        end
        2: if (in_valid) begin
          wq.push_back($signed(in_data));
          e_o = wq[0];
          foreach (wq[i]) if (wq[i] > e_o) e_o = wq[i];
          if (wq.size() == m_ws) begin e_ov = 1; wq.delete(); end
          left--;
          if (left == 0) begin ph = 3; e_done = 1; end
        end
        default: ph = 0;
      endcase
    end
  end
  assign e_busy = (ph == 1) || (ph == 2);
  assign e_rdy  = ph == 2;

  always @(negedge clk) if (armed) begin
    chk("out_valid", out_valid, e_ov);
    chk("out_data", $signed(out_data), e_o);
    chk("done", done, e_done);
    chk("busy", busy, e_busy);
    chk("in_ready", in_ready, e_rdy);
  end

  always @(negedge clk) if (out_valid) got.push_back($signed(out_data));

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic start_job(input int ws, input int nw);
    got.delete();
    win_size = 8'(ws); num_win = 8'(nw); start = 1; tick;
    start = 0; tick;
  endtask

  task automatic feed(input bit v, input int d);
    in_valid = v; in_data = 32'(d); tick;
  endtask

  task automatic idle(input int n);
    in_valid = 0; in_data = 32'd777;
    repeat (n) tick;
  endtask

  task automatic check_got(input string nm);
    chk({nm, " count"}, got.size(), want.size());
    for (int i = 0; i < want.size(); i++) if (i < got.size()) chk(nm, got[i], want[i]);
  endtask

  initial begin
    #1 rst = 1;
    repeat (2) tick;
    rst = 0; armed = 1; tick;
    start_job(4, 2);
    feed(1, 3); feed(1, -7); feed(1, 9); feed(1, 1);
    feed(1, -2); feed(1, -5); feed(1, -1); feed(1, -8);
    idle(3);
    want = {32'sd9, -32'sd1}; check_got("basic");
    start_job(4, 2);
    feed(1, 3); feed(1, -7); feed(0, 100); feed(0, 100); feed(0, 100); feed(1, 9); feed(1, 1);
    feed(1, -2); feed(1, -5); feed(0, 100); feed(0, 100); feed(0, 100); feed(1, -1); feed(1, -8);
    idle(3);
    check_got("stalls");
    start_job(1, 3);
    feed(1, -4); feed(1, 5); feed(1, 0);
    idle(3);
    want = {-32'sd4, 32'sd5, 32'sd0}; check_got("pass");
    start_job(0, 5);
    chk("zero done", done, 1);
    chk("zero data", $signed(out_data), 0);
    idle(3);
    want.delete(); check_got("zero");
    start_job(4, 1);
    feed(1, 5); feed(1, 6);
    in_valid = 0; rst = 1; #1;
    chk("rst busy", busy, 0);
    chk("rst in_ready", in_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst done", done, 0);
    tick; rst = 0; tick;
    start_job(2, 1);
    feed(1, -3); feed(1, -6);
    idle(3);
    want = {-32'sd3}; check_got("rst job");
    start_job(2, 2);
    feed(1, MINV); feed(1, MINV);
    start = 1; feed(1, MAXV); start = 0; feed(1, 0);
    idle(4);
    want = {MINV, MAXV}; check_got("edge");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
